// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; runtime baud divisor, 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the parity ports and the PARITY state.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_BITS-1:0]              data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   input  logic [DIV_W-1:0]                  baud_div_i,
   input  logic                              two_stop_i,
`ifdef UART_TX_PARITY_EN
   input  logic                              parity_en_i,
   input  logic                              parity_odd_i,
`endif
   output logic                              tx_o,
   output logic                              busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int BIT_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_TX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]     level_q;
   logic                 full, empty, push, pop;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d, div_q;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 two_stop_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 tx_q, tx_d;
   logic                 bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_en_q, par_odd_q;
`endif

   assign full    = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty   = (level_q == '0);
   // Push depends only on full, so a word offered at full is refused even when a pop frees a slot.
   assign push    = valid_i && !full;
   assign bit_end = (baud_cnt_q == div_q);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: if (bit_end) state_d = S_DATA;
         S_DATA: begin
            if (bit_end && bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
               state_d = par_en_q ? S_PARITY : S_STOP;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (bit_end) state_d = S_STOP;
`endif
         S_STOP: begin
            // Last stop period ends: chain straight into the next frame if one is waiting.
            if (bit_end && stop_cnt_q == two_stop_q) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      baud_cnt_d = (state_q == S_IDLE || bit_end) ? '0 : baud_cnt_q + DIV_W'(1);

      bit_cnt_d = bit_cnt_q;
      if (state_q == S_DATA && bit_end) bit_cnt_d = bit_cnt_q + BIT_W'(1);
      if (state_d != S_DATA) bit_cnt_d = '0;

      stop_cnt_d = (state_d == S_STOP) ? (stop_cnt_q | (state_q == S_STOP && bit_end)) : 1'b0;

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_q[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = (^data_q) ^ par_odd_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         div_q      <= '0;
         two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         if (pop) begin
            div_q      <= baud_div_i;
            two_stop_q <= two_stop_i;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= parity_en_i;
            par_odd_q  <= parity_odd_i;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pop) data_q <= mem[rd_ptr_q];
   end

   assign ready_o      = !full;
   assign busy_o       = (state_q != S_IDLE) || !empty;
   assign tx_o         = tx_q;
   assign fifo_level_o = level_q;

endmodule
